axicb_slv_switch_wr: RTL
========================

Name: axicb_slv_switch_wr

Overview:
- Write-path slave switch for the AXI crossbar; sits directly upstream of the per-slave master-switch write stages.
- Takes one master's AW/W/B channels and decodes each AW address to one of SLV_NB slave ports.
- Routes the W bursts to the same slave, in AW acceptance order.
- Arbitrates B responses from all slave ports back to the master.
- Unmapped addresses are absorbed locally and answered with a DECERR response.

Parameters:
- AXI_ADDR_W, 16, address width in bits.
- AXI_ID_W, 8, ID width in bits.
- SLV_NB, 4, number of slave ports (1..4).
- SLVx_START_ADDR (x=0..3), 'h0000/'h1000/'h2000/'h3000, inclusive lower bound of slave x region.
- SLVx_END_ADDR (x=0..3), 'h0FFF/'h1FFF/'h2FFF/'h3FFF, inclusive upper bound of slave x region.
- ROUTE_DEPTH, 8, outstanding-AW route FIFO depth (power of 2).
- AWCH_W, 24, AW payload width; ID is bits [AXI_ID_W-1:0], address is bits [AXI_ID_W+:AXI_ADDR_W].
- WCH_W, 8, W payload width.
- BCH_W, 10, B payload width; {RESP[1:0], ID}.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset.
- i_awvalid/i_awready  in/out  1  master AW handshake; i_awch in AWCH_W.
- i_wvalid/i_wready  in/out  1  master W handshake; i_wlast in 1; i_wch in WCH_W.
- i_bvalid/i_bready  out/in  1  master B handshake; i_bch out BCH_W.
- o_awvalid/o_awready  out/in  SLV_NB  per-slave AW handshake; o_awch out AWCH_W, shared.
- o_wvalid/o_wready  out/in  SLV_NB  per-slave W handshake; o_wlast out 1 and o_wch out WCH_W, both shared.
- o_bvalid/o_bready  in/out  SLV_NB  per-slave B handshake; o_bch in SLV_NB*BCH_W.

Behaviour:
- Reset: async on aresetn low, sync on srst high; both give identical state.
  - All valid/ready outputs 0.
  - Route FIFO empty; DECERR register empty.
  - B arbiter pointer at slave 0.
- Decode (combinational):
  - hit[x] = START_x <= addr <= END_x; lowest index wins on overlap.
  - miss = no hit.
- AW path:
  - o_awvalid[x] = i_awvalid & hit[x] & !route_full.
  - i_awready = route_full ? 0 : (miss ? 1 : o_awready[sel]).
  - o_awch = i_awch passthrough.
  - Zero latency; no AW register.
- Route FIFO:
  - Push on each accepted AW. Entry = {onehot sel, err flag, ID}.
  - Pull on W handshake with i_wlast.
  - Full: blocks AW (i_awready=0). Empty: blocks W (i_wready=0, all o_wvalid=0).
  - Simultaneous push and pull when full: only the pull occurs; AW stays stalled that cycle.
- W path, head entry non-error:
  - o_wvalid[sel] = i_wvalid; i_wready = o_wready[sel].
  - o_wlast/o_wch passthrough.
- W path, head entry error:
  - i_wready = !err_b_valid; all o_wvalid=0; data discarded.
  - On last beat: err_b_valid<=1, err_b_id<=head ID.
- DECERR register:
  - Single entry, response {2'b11, ID}.
  - Cleared on its B grant handshake.
  - Error W bursts stall while it is occupied.
- B arbitration:
  - Requesters: o_bvalid[0..SLV_NB-1] plus err_b_valid as index SLV_NB.
  - Round-robin: search starts at pointer, pointer moves to grant+1 (mod SLV_NB+1) after each handshake.
  - Grant is locked while i_bvalid & !i_bready; a lower-index new request must not preempt.
  - i_bvalid = any granted valid; i_bch = granted payload; o_bready[g] = i_bready & (g==grant).
- No ordering enforced across slaves for B; ID-based master matching is downstream's job.

Test Plan:
- Single write to 'h1004, ID 'h05, 4 beats -> o_awvalid=4'b0010 same cycle; 4 beats only on o_wvalid[1]; slave1 B {00,05} appears on i_bch.
- AWs to 'h0000, 'h3000, 'h2000 back-to-back, W held off -> 3 route entries; W bursts then reach slaves 0, 3, 2 strictly in that order.
- Write to 'h8000, ID 'h3C, 2 beats -> no o_awvalid; i_awready=1; W sunk with all o_wvalid=0; i_bch={11,3C} one cycle after wlast handshake.
- Slaves 0, 2 and DECERR raise B together with i_bready=1 -> grants 0, 2, DECERR on consecutive handshakes; pointer ends at 0 (SLV_NB=4, index 4 wraps).
- ROUTE_DEPTH=8 AWs with no W traffic -> 9th AW sees i_awready=0 until one wlast handshake, then accepted the next cycle.
- aresetn low mid-burst (beat 2 of 4) -> all outputs 0 asynchronously; after release FIFO empty and new AW to 'h2000 routes correctly.

Source files
------------

// File: rtl/axicb_slv_switch_wr_if.sv
// AW/W/B bundle between one crossbar master and the write-path slave switch, plus the switch's per-slave ports.
// The slave modport is the switch's view; the master modport is whatever drives and consumes both sides.
interface axicb_slv_switch_wr_if #(
    parameter int SLV_NB = 4,
    parameter int AWCH_W = 24,
    parameter int WCH_W  = 8,
    parameter int BCH_W  = 10
);
    logic                    i_awvalid;
    logic                    i_awready;
    logic [AWCH_W-1:0]       i_awch;
    logic                    i_wvalid;
    logic                    i_wready;
    logic                    i_wlast;
    logic [WCH_W-1:0]        i_wch;
    logic                    i_bvalid;
    logic                    i_bready;
    logic [BCH_W-1:0]        i_bch;

    logic [SLV_NB-1:0]       o_awvalid;
    logic [SLV_NB-1:0]       o_awready;
    logic [AWCH_W-1:0]       o_awch;
    logic [SLV_NB-1:0]       o_wvalid;
    logic [SLV_NB-1:0]       o_wready;
    logic                    o_wlast;
    logic [WCH_W-1:0]        o_wch;
    logic [SLV_NB-1:0]       o_bvalid;
    logic [SLV_NB-1:0]       o_bready;
    logic [SLV_NB*BCH_W-1:0] o_bch;

    modport slave (
        input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
               o_awready, o_wready, o_bvalid, o_bch,
        output i_awready, i_wready, i_bvalid, i_bch,
               o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
    );

    modport master (
        output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
               o_awready, o_wready, o_bvalid, o_bch,
        input  i_awready, i_wready, i_bvalid, i_bch,
               o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
    );
endinterface

// File: rtl/axicb_slv_switch_wr.sv
// Write-path slave switch: decodes AW to a slave port, steers W bursts in AW order, round-robins B back.
// Latency: AW/W/B are combinational passthroughs; a DECERR B appears 1 cycle after the error burst's last beat.
// Backpressure: AW stalls on full route FIFO; W stalls on empty FIFO or busy DECERR slot; B grant held until taken.
module axicb_slv_switch_wr #(
    parameter int AXI_ADDR_W = 16,
    parameter int AXI_ID_W   = 8,
    parameter int SLV_NB     = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
    parameter int ROUTE_DEPTH = 8,
    parameter int AWCH_W      = 24,
    parameter int WCH_W       = 8,
    parameter int BCH_W       = 10
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic srst,
    axicb_slv_switch_wr_if.slave bus
);
    localparam int NB_REQ = SLV_NB + 1;
    localparam int GW     = $clog2(NB_REQ);
    localparam int RA_W   = $clog2(ROUTE_DEPTH);
    localparam int RT_W   = SLV_NB + 1 + AXI_ID_W;
    localparam logic [GW-1:0] ERR_IDX = GW'(SLV_NB);
    localparam logic [AXI_ADDR_W-1:0] SLV_START [4] =
        '{SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
    localparam logic [AXI_ADDR_W-1:0] SLV_END [4] =
        '{SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};

    logic                  en;
    logic [AWCH_W-1:0]     aw_dat;
    logic [WCH_W-1:0]      w_dat;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [SLV_NB-1:0]     aw_sel;
    logic                  aw_miss;
    logic                  aw_push;

    logic [RT_W-1:0]       rt_mem [ROUTE_DEPTH];
    logic [RA_W:0]         rt_wr, rt_rd;
    logic                  route_full, rt_vld;
    logic [RT_W-1:0]       rt_head;
    logic [SLV_NB-1:0]     rt_sel;
    logic                  rt_err;
    logic [AXI_ID_W-1:0]   rt_id;
    logic                  w_hs, w_pop;

    logic                  err_b_valid;
    logic [AXI_ID_W-1:0]   err_b_id;
    logic [BCH_W-1:0]      err_bch;

    logic [NB_REQ-1:0]     b_req;
    logic [GW-1:0]         b_ptr, b_lock_idx, rr_grant, b_grant;
    logic                  b_locked, rr_found, b_hs;
    int                    rr_idx;
    logic [BCH_W-1:0]      b_dat;

    // Outputs are forced idle while either reset is held, not just after the next edge.
    assign en = aresetn & ~srst;

    assign aw_dat  = bus.i_awch;
    assign w_dat   = bus.i_wch;
    assign aw_id   = aw_dat[AXI_ID_W-1:0];
    assign aw_addr = aw_dat[AXI_ID_W +: AXI_ADDR_W];

    always_comb begin
        aw_sel  = '0;
        aw_miss = 1'b1;
        for (int x = 0; x < SLV_NB; x++) begin
            if (aw_miss && aw_addr >= SLV_START[x] && aw_addr <= SLV_END[x]) begin
                aw_sel[x] = 1'b1;
                aw_miss   = 1'b0;
            end
        end
    end

    assign bus.o_awvalid = {SLV_NB{en & bus.i_awvalid & ~route_full}} & aw_sel;
    assign bus.i_awready = en & ~route_full & (aw_miss | (|(bus.o_awready & aw_sel)));
    assign bus.o_awch    = aw_dat;
    assign aw_push       = bus.i_awvalid & bus.i_awready;

    // Route FIFO: one entry per accepted AW, retired by the last W beat of its burst.
    assign route_full = (rt_wr[RA_W] != rt_rd[RA_W]) && (rt_wr[RA_W-1:0] == rt_rd[RA_W-1:0]);
    assign rt_vld     = (rt_wr != rt_rd);
    assign rt_head    = rt_mem[rt_rd[RA_W-1:0]];
    assign rt_sel     = rt_head[RT_W-1 -: SLV_NB];
    assign rt_err     = rt_head[AXI_ID_W];
    assign rt_id      = rt_head[AXI_ID_W-1:0];

    always_ff @(posedge aclk) begin
        if (aw_push) begin
            rt_mem[rt_wr[RA_W-1:0]] <= {aw_sel, aw_miss, aw_id};
        end
    end

    always_comb begin
        bus.o_wvalid = '0;
        bus.i_wready = 1'b0;
        if (en && rt_vld) begin
            if (rt_err) begin
                bus.i_wready = ~err_b_valid;
            end else begin
                bus.o_wvalid = {SLV_NB{bus.i_wvalid}} & rt_sel;
                bus.i_wready = |(bus.o_wready & rt_sel);
            end
        end
    end

    assign bus.o_wlast = bus.i_wlast;
    assign bus.o_wch   = w_dat;
    assign w_hs        = bus.i_wvalid & bus.i_wready;
    assign w_pop       = w_hs & bus.i_wlast;

    assign err_bch = BCH_W'({2'b11, err_b_id});
    assign b_req   = {err_b_valid, bus.o_bvalid};

    always_comb begin
        rr_grant = b_ptr;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NB_REQ; k++) begin
            rr_idx = int'(b_ptr) + k;
            if (rr_idx >= NB_REQ) rr_idx = rr_idx - NB_REQ;
            if (!rr_found && b_req[rr_idx]) begin
                rr_grant = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // A stalled grant is pinned so a late lower-index request cannot swap the payload under the master.
    assign b_grant      = b_locked ? b_lock_idx : rr_grant;
    assign bus.i_bvalid = en & b_req[b_grant];
    assign bus.i_bch    = b_dat;
    assign b_hs         = bus.i_bvalid & bus.i_bready;

    always_comb begin
        b_dat        = err_bch;
        bus.o_bready = '0;
        for (int g = 0; g < SLV_NB; g++) begin
            if (b_grant == GW'(g)) begin
                b_dat           = bus.o_bch[g*BCH_W +: BCH_W];
                bus.o_bready[g] = en & bus.i_bready;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rt_wr       <= '0;
            rt_rd       <= '0;
            err_b_valid <= 1'b0;
            err_b_id    <= '0;
            b_ptr       <= '0;
            b_locked    <= 1'b0;
            b_lock_idx  <= '0;
        end else if (srst) begin
            rt_wr       <= '0;
            rt_rd       <= '0;
            err_b_valid <= 1'b0;
            err_b_id    <= '0;
            b_ptr       <= '0;
            b_locked    <= 1'b0;
            b_lock_idx  <= '0;
        end else begin
            if (aw_push) rt_wr <= rt_wr + 1'b1;
            if (w_pop)   rt_rd <= rt_rd + 1'b1;

            if (b_hs && b_grant == ERR_IDX) begin
                err_b_valid <= 1'b0;
            end
            if (w_pop && rt_err) begin
                err_b_valid <= 1'b1;
                err_b_id    <= rt_id;
            end

            if (b_hs) begin
                b_ptr    <= (b_grant == ERR_IDX) ? '0 : b_grant + 1'b1;
                b_locked <= 1'b0;
            end else begin
                b_locked   <= bus.i_bvalid;
                b_lock_idx <= b_grant;
            end
        end
    end
endmodule
